// File: rtl/control_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : control_seq_if
// Purpose  : Control-side signal bundle between the sequencer and the
//            datapath / memory. The shared data bus is not part of this
//            bundle. It is a plain inout port on the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface control_seq_if #(
    parameter int REG_IDX_W = 5,
    parameter int ALU_OP_W  = 4
);
    logic                 mem_ready;
    logic                 alu_eq;
    logic                 alu_lt;
    logic                 alu_ltu;
    logic [REG_IDX_W-1:0] reg_idx;
    logic                 pc_addr;
    logic                 pc_bus;
    logic                 pc_inc;
    logic                 pc_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_en;
    logic                 reg_write;
    logic                 a_bus;
    logic                 a_addr;
    logic                 a_write;
    logic                 b_bus;
    logic                 b_addr;
    logic                 b_write;
    logic                 alu_bus;
    logic                 alu_addr;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 halted;
    logic [3:0]           state_o;

    // Sequencer side
    modport slave (
        input  mem_ready, alu_eq, alu_lt, alu_ltu,
        output reg_idx, pc_addr, pc_bus, pc_inc, pc_write, mem_read, mem_write,
               reg_en, reg_write, a_bus, a_addr, a_write, b_bus, b_addr, b_write,
               alu_bus, alu_addr, alu_op, halted, state_o
    );

    // Datapath / memory side
    modport master (
        output mem_ready, alu_eq, alu_lt, alu_ltu,
        input  reg_idx, pc_addr, pc_bus, pc_inc, pc_write, mem_read, mem_write,
               reg_en, reg_write, a_bus, a_addr, a_write, b_bus, b_addr, b_write,
               alu_bus, alu_addr, alu_op, halted, state_o
    );
endinterface
`default_nettype wire

// File: rtl/control_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : control_seq
// Purpose  : Multi-cycle control sequencer for a bus-based RV32 datapath.
//            Fetches from the shared bus, decodes, drives immediates onto the
//            bus and emits single-state strobes registered on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module control_seq #(
    parameter int XLEN        = 32,
    parameter int REG_IDX_W   = 5,
    parameter int ALU_OP_W    = 4,
    parameter int MEM_WAIT_EN = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    inout  wire       [XLEN-1:0] bus,
    control_seq_if.slave         ctl
);
    // Debug encoding visible on state_o
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_REGA = 4'd1, S_REGB = 4'd2, S_EXEC = 4'd3,
        S_EXEC1 = 4'd4, S_PCA  = 4'd5, S_PCB  = 4'd6, S_PCW  = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    localparam logic [4:0] C_LOAD   = 5'b00000;
    localparam logic [4:0] C_STORE  = 5'b01000;
    localparam logic [4:0] C_OP     = 5'b01100;
    localparam logic [4:0] C_OP_IMM = 5'b00100;
    localparam logic [4:0] C_LUI    = 5'b01101;
    localparam logic [4:0] C_BRANCH = 5'b11000;
    localparam logic [4:0] C_AUIPC  = 5'b00101;

    typedef struct packed {
        logic pc_addr, pc_bus, pc_inc, pc_write;
        logic mem_read, mem_write, reg_en, reg_write;
        logic a_bus, a_addr, a_write, b_bus, b_addr, b_write;
        logic alu_bus, alu_addr, imm_en;
    } strobe_t;

    state_t               r_state, w_next;
    logic [XLEN-1:0]      r_inst;
    strobe_t              w_stb, r_stb;
    logic [REG_IDX_W-1:0] w_reg_idx, r_reg_idx;
    logic [ALU_OP_W-1:0]  w_alu_op, r_alu_op;
    logic [XLEN-1:0]      w_imm, r_imm;
    logic                 r_halted;
    logic                 w_ready, w_taken, w_legal;

    // Instruction fields
    logic [4:0]           w_cls;
    logic [2:0]           w_f3;
    logic [REG_IDX_W-1:0] w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u;
    logic                 w_unused_inst;

    assign w_cls   = r_inst[6:2];
    assign w_f3    = r_inst[14:12];
    assign w_rd    = REG_IDX_W'(r_inst[11:7]);
    assign w_rs1   = REG_IDX_W'(r_inst[19:15]);
    assign w_rs2   = REG_IDX_W'(r_inst[24:20]);
    assign w_imm_i = XLEN'($signed(r_inst[31:20]));
    assign w_imm_s = XLEN'($signed({r_inst[31:25], r_inst[11:7]}));
    assign w_imm_b = XLEN'($signed({r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({r_inst[31:12], 12'b0}));
    // Bits outside the RV32 encoding (size bits, upper XLEN bits) carry no meaning here
    assign w_unused_inst = ^r_inst;

    generate
        if (MEM_WAIT_EN != 0) begin : g_mem_wait
            assign w_ready = ctl.mem_ready;
        end else begin : g_mem_nowait
            assign w_ready = 1'b1;
        end
    endgenerate

    // Legality: supported opcode classes, and no reserved branch funct3
    always_comb begin
        w_legal = 1'b0;
        case (w_cls)
            C_LOAD, C_STORE, C_OP, C_OP_IMM, C_LUI, C_AUIPC: w_legal = 1'b1;
            C_BRANCH: w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
            default:  w_legal = 1'b0;
        endcase
    end

    // Branch condition selected by funct3 from the ALU compare flags
    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            3'b000:  w_taken =  ctl.alu_eq;
            3'b001:  w_taken = !ctl.alu_eq;
            3'b100:  w_taken =  ctl.alu_lt;
            3'b101:  w_taken = !ctl.alu_lt;
            3'b110:  w_taken =  ctl.alu_ltu;
            3'b111:  w_taken = !ctl.alu_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // State and instruction register advance on the rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_inst  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && w_ready) begin
                r_inst <= bus;
            end
        end
    end

    // Next state and the strobe set belonging to the current state
    always_comb begin
        w_next    = r_state;
        w_stb     = '0;
        w_reg_idx = '0;
        w_alu_op  = '0;
        w_imm     = '0;
        case (r_state)
            S_FETCH: begin
                w_stb.pc_addr  = 1'b1;
                w_stb.mem_read = 1'b1;
                if (w_ready) w_next = S_REGA;
            end
            S_REGA: begin
                if (!w_legal) begin
                    w_next = S_HALT;
                end else begin
                    w_reg_idx     = w_rs1;
                    w_stb.reg_en  = 1'b1;
                    w_stb.a_write = 1'b1;
                    // Branch and AUIPC still need the old PC later on
                    w_stb.pc_inc  = (w_cls != C_BRANCH) && (w_cls != C_AUIPC);
                    w_next        = S_REGB;
                end
            end
            S_REGB: begin
                w_stb.b_write = 1'b1;
                w_next        = S_EXEC;
                if (w_cls == C_OP_IMM || w_cls == C_LOAD) begin
                    w_stb.imm_en = 1'b1;
                    w_imm        = w_imm_i;
                end else if (w_cls == C_STORE) begin
                    w_stb.imm_en = 1'b1;
                    w_imm        = w_imm_s;
                end else begin
                    w_reg_idx    = w_rs2;
                    w_stb.reg_en = 1'b1;
                end
            end
            S_EXEC: begin
                case (w_cls)
                    C_LOAD: begin
                        w_stb.alu_addr  = 1'b1;
                        w_stb.mem_read  = 1'b1;
                        w_reg_idx       = w_rd;
                        w_stb.reg_write = w_ready;
                        if (w_ready) w_next = S_FETCH;
                    end
                    C_STORE: begin
                        w_stb.alu_addr = 1'b1;
                        w_next         = S_EXEC1;
                    end
                    C_OP, C_OP_IMM: begin
                        if (w_cls == C_OP)
                            w_alu_op = ALU_OP_W'({r_inst[30], w_f3});
                        else
                            w_alu_op = ALU_OP_W'({r_inst[30] && (w_f3 == 3'b101), w_f3});
                        w_stb.alu_bus   = 1'b1;
                        w_reg_idx       = w_rd;
                        w_stb.reg_write = 1'b1;
                        w_next          = S_FETCH;
                    end
                    C_LUI: begin
                        w_stb.imm_en    = 1'b1;
                        w_imm           = w_imm_u;
                        w_reg_idx       = w_rd;
                        w_stb.reg_write = 1'b1;
                        w_next          = S_FETCH;
                    end
                    C_BRANCH: begin
                        if (w_taken) begin
                            w_next = S_PCA;
                        end else begin
                            w_stb.pc_inc = 1'b1;
                            w_next       = S_FETCH;
                        end
                    end
                    C_AUIPC: w_next = S_PCA;
                    default: w_next = S_HALT;
                endcase
            end
            S_EXEC1: begin
                // Store data is read from rs2 while the address is held
                w_stb.alu_addr  = 1'b1;
                w_reg_idx       = w_rs2;
                w_stb.reg_en    = 1'b1;
                w_stb.mem_write = 1'b1;
                if (w_ready) w_next = S_FETCH;
            end
            S_PCA: begin
                w_stb.pc_bus  = 1'b1;
                w_stb.a_write = 1'b1;
                w_next        = S_PCB;
            end
            S_PCB: begin
                w_stb.imm_en  = 1'b1;
                w_imm         = (w_cls == C_BRANCH) ? w_imm_b : w_imm_u;
                w_stb.b_write = 1'b1;
                w_next        = S_PCW;
            end
            S_PCW: begin
                w_stb.alu_bus = 1'b1;
                if (w_cls == C_BRANCH) begin
                    w_stb.pc_write = 1'b1;
                end else begin
                    w_reg_idx       = w_rd;
                    w_stb.reg_write = 1'b1;
                    w_stb.pc_inc    = 1'b1;
                end
                w_next = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are re-registered every falling edge so each lasts one state
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_stb     <= '0;
            r_reg_idx <= '0;
            r_alu_op  <= '0;
            r_imm     <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_stb     <= w_stb;
            r_reg_idx <= w_reg_idx;
            r_alu_op  <= w_alu_op;
            r_imm     <= w_imm;
            r_halted  <= (r_state == S_HALT);
        end
    end

    assign bus           = r_stb.imm_en ? r_imm : {XLEN{1'bz}};
    assign ctl.reg_idx   = r_reg_idx;
    assign ctl.alu_op    = r_alu_op;
    assign ctl.halted    = r_halted;
    assign ctl.state_o   = r_state;
    assign ctl.pc_addr   = r_stb.pc_addr;
    assign ctl.pc_bus    = r_stb.pc_bus;
    assign ctl.pc_inc    = r_stb.pc_inc;
    assign ctl.pc_write  = r_stb.pc_write;
    assign ctl.mem_read  = r_stb.mem_read;
    assign ctl.mem_write = r_stb.mem_write;
    assign ctl.reg_en    = r_stb.reg_en;
    assign ctl.reg_write = r_stb.reg_write;
    assign ctl.a_bus     = r_stb.a_bus;
    assign ctl.a_addr    = r_stb.a_addr;
    assign ctl.a_write   = r_stb.a_write;
    assign ctl.b_bus     = r_stb.b_bus;
    assign ctl.b_addr    = r_stb.b_addr;
    assign ctl.b_write   = r_stb.b_write;
    assign ctl.alu_bus   = r_stb.alu_bus;
    assign ctl.alu_addr  = r_stb.alu_addr;
endmodule
`default_nettype wire

// File: tb/tb_control_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_control_seq
// Purpose  : Scoreboard bench for control_seq. A reference model expands each
//            instruction into its expected per-cycle observations; a monitor
//            compares them against the DUT every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_seq;
    // Debug state codes published on state_o
    localparam logic [3:0] ST_FETCH = 4'd0, ST_REGA = 4'd1, ST_REGB = 4'd2, ST_EXEC = 4'd3,
                           ST_EXEC1 = 4'd4, ST_PCA = 4'd5, ST_PCB = 4'd6, ST_PCW = 4'd7,
                           ST_HALT = 4'd8;
    // Strobe bit masks in the order of w_act_strb below
    localparam logic [15:0] PA = 16'h0001, PB = 16'h0002, PI = 16'h0004, PW = 16'h0008,
                            MRD = 16'h0010, MWR = 16'h0020, REN = 16'h0040, RWR = 16'h0080,
                            AW = 16'h0400, BW = 16'h2000, ABUS = 16'h4000, AADR = 16'h8000;
    localparam logic [4:0] C_LOAD = 5'b00000, C_STORE = 5'b01000, C_OP = 5'b01100,
                           C_OPI = 5'b00100, C_LUI = 5'b01101, C_BR = 5'b11000, C_AUIPC = 5'b00101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_val = '0;
    wire  [31:0] bus;

    always #5 clk = ~clk;
    assign bus = tb_drv ? tb_val : 32'bz;

    control_seq_if #(.REG_IDX_W(5), .ALU_OP_W(4)) ctl ();

    control_seq #(.XLEN(32), .REG_IDX_W(5), .ALU_OP_W(4), .MEM_WAIT_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .ctl   (ctl)
    );

    wire [15:0] w_act_strb = {ctl.alu_addr, ctl.alu_bus, ctl.b_write, ctl.b_addr, ctl.b_bus,
                              ctl.a_write, ctl.a_addr, ctl.a_bus, ctl.reg_write, ctl.reg_en,
                              ctl.mem_write, ctl.mem_read, ctl.pc_write, ctl.pc_inc,
                              ctl.pc_bus, ctl.pc_addr};

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] strb;
        logic        hlt;
        logic        ci;
        logic [4:0]  idx;
        logic        co;
        logic [3:0]  op;
        logic        cb;
        logic [31:0] bv;
        logic        mr;
        logic        db;
        logic [31:0] dv;
    } exp_t;

    exp_t sb_q[$];
    exp_t seq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t rec(input logic [3:0] st, input logic [15:0] strb, input logic mr);
        exp_t e;
        e      = '0;
        e.st   = st;
        e.strb = strb;
        e.mr   = mr;
        e.hlt  = (st == ST_HALT);
        return e;
    endfunction

    function automatic exp_t wi(input exp_t e, input logic [4:0] idx);
        e.ci = 1'b1; e.idx = idx; return e;
    endfunction

    function automatic exp_t wo(input exp_t e, input logic [3:0] op);
        e.co = 1'b1; e.op = op; return e;
    endfunction

    function automatic exp_t wb(input exp_t e, input logic [31:0] v);
        e.cb = 1'b1; e.bv = v; return e;
    endfunction

    function automatic logic rb();
        return logic'($urandom % 2);
    endfunction

    // Reference model: expected cycle-by-cycle observations for one instruction
    task automatic build(input logic [31:0] inst, input int fw, input int ew,
                         input logic eq, input logic lt, input logic ltu, output bit ill);
        logic [4:0]  cls, rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] imm_i, imm_s, imm_b, imm_u;
        logic        taken;
        exp_t        e;
        cls   = inst[6:2];
        f3    = inst[14:12];
        rd    = inst[11:7];
        rs1   = inst[19:15];
        rs2   = inst[24:20];
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u = {inst[31:12], 12'b0};
        case (f3)
            3'd0: taken = eq;   3'd1: taken = !eq;
            3'd4: taken = lt;   3'd5: taken = !lt;
            3'd6: taken = ltu;  default: taken = !ltu;
        endcase
        ill = !(cls inside {C_LOAD, C_STORE, C_OP, C_OPI, C_LUI, C_AUIPC, C_BR}) ||
              (cls == C_BR && (f3 == 3'd2 || f3 == 3'd3));
        seq.delete();
        for (int w = 0; w <= fw; w++) begin
            e = rec(ST_FETCH, PA | MRD, (w == fw));
            e.db = 1'b1; e.dv = inst;
            seq.push_back(e);
        end
        if (ill) begin
            seq.push_back(rec(ST_REGA, 16'h0, rb()));
            for (int h = 0; h < 20; h++) seq.push_back(rec(ST_HALT, 16'h0, rb()));
            return;
        end
        seq.push_back(wi(rec(ST_REGA, REN | AW | ((cls == C_BR || cls == C_AUIPC) ? 16'h0 : PI), rb()), rs1));
        if (cls == C_OPI || cls == C_LOAD)  seq.push_back(wb(rec(ST_REGB, BW, rb()), imm_i));
        else if (cls == C_STORE)            seq.push_back(wb(rec(ST_REGB, BW, rb()), imm_s));
        else                                seq.push_back(wi(rec(ST_REGB, REN | BW, rb()), rs2));
        case (cls)
            C_LOAD: begin
                for (int w = 0; w < ew; w++) seq.push_back(wo(wi(rec(ST_EXEC, AADR | MRD, 1'b0), rd), 4'd0));
                seq.push_back(wo(wi(rec(ST_EXEC, AADR | MRD | RWR, 1'b1), rd), 4'd0));
            end
            C_STORE: begin
                seq.push_back(wo(rec(ST_EXEC, AADR, rb()), 4'd0));
                for (int w = 0; w <= ew; w++) seq.push_back(wi(rec(ST_EXEC1, AADR | REN | MWR, (w == ew)), rs2));
            end
            C_OP:  seq.push_back(wo(wi(rec(ST_EXEC, ABUS | RWR, rb()), rd), {inst[30], f3}));
            C_OPI: seq.push_back(wo(wi(rec(ST_EXEC, ABUS | RWR, rb()), rd), {inst[30] & (f3 == 3'd5), f3}));
            C_LUI: seq.push_back(wb(wi(rec(ST_EXEC, RWR, rb()), rd), imm_u));
            default: begin
                if (cls == C_BR && !taken) begin
                    seq.push_back(rec(ST_EXEC, PI, rb()));
                end else begin
                    seq.push_back(rec(ST_EXEC, 16'h0, rb()));
                    seq.push_back(rec(ST_PCA, PB | AW, rb()));
                    seq.push_back(wo(wb(rec(ST_PCB, BW, rb()), (cls == C_BR) ? imm_b : imm_u), 4'd0));
                    if (cls == C_BR) seq.push_back(wo(rec(ST_PCW, ABUS | PW, rb()), 4'd0));
                    else             seq.push_back(wo(wi(rec(ST_PCW, ABUS | RWR | PI, rb()), rd), 4'd0));
                end
            end
        endcase
    endtask

    task automatic play(input int upto, input logic eq, input logic lt, input logic ltu);
        for (int i = 0; i < upto; i++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            if (i == 0) begin
                ctl.alu_eq = eq; ctl.alu_lt = lt; ctl.alu_ltu = ltu;
            end
            ctl.mem_ready = seq[i].mr;
            tb_drv        = seq[i].db;
            tb_val        = seq[i].dv;
            sb_q.push_back(seq[i]);
        end
    endtask

    // Asynchronous reset raised mid-cycle; everything must clear before the next edge
    task automatic do_reset();
        @(posedge clk); #1;
        tb_drv        = 1'b0;
        ctl.mem_ready = rb();
        sb_q.push_back(wo(wi(rec(ST_FETCH, 16'h0, 1'b0), 5'd0), 4'd0));
        #1 reset = 1'b1;
    endtask

    task automatic run_inst(input logic [31:0] inst, input int fw, input int ew, input int abort_at,
                            input logic eq, input logic lt, input logic ltu);
        bit ill;
        build(inst, fw, ew, eq, lt, ltu, ill);
        if (abort_at > 0 && abort_at < seq.size()) begin
            play(abort_at, eq, lt, ltu);
            do_reset();
        end else begin
            play(seq.size(), eq, lt, ltu);
            if (ill) do_reset();
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [2:0]  t;
        r = $urandom;
        t = 3'($urandom_range(5, 0));
        case ($urandom_range(8, 0))
            0: r[6:0] = 7'b0110011;
            1: r[6:0] = 7'b0010011;
            2: begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
            3: begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
            4: begin r[6:0] = 7'b1100011; r[14:12] = (t < 3'd2) ? t : t + 3'd2; end
            5: r[6:0] = 7'b0110111;
            6: r[6:0] = 7'b0010111;
            7: r[6:0] = ($urandom % 2) ? 7'b1101111 : 7'b1110011;
            default: begin r[6:0] = 7'b1100011; r[14:12] = ($urandom % 2) ? 3'd2 : 3'd3; end
        endcase
        return r;
    endfunction

    // Monitor: one scoreboard entry is retired per cycle, after the falling edge
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk); #1;
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                ok = 1'b1;
                if (ctl.state_o !== e.st)            ok = 1'b0;
                if (w_act_strb !== e.strb)           ok = 1'b0;
                if (ctl.halted !== e.hlt)            ok = 1'b0;
                if (e.ci && (ctl.reg_idx !== e.idx)) ok = 1'b0;
                if (e.co && (ctl.alu_op !== e.op))   ok = 1'b0;
                if (e.cb && (bus !== e.bv))          ok = 1'b0;
                n_cmp++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL cycle@%0t: got st=%0d strb=%h halt=%b idx=%0d op=%h bus=%h | want st=%0d strb=%h halt=%b idx=%0d(%b) op=%h(%b) bus=%h(%b)",
                             $time, ctl.state_o, w_act_strb, ctl.halted, ctl.reg_idx, ctl.alu_op, bus,
                             e.st, e.strb, e.hlt, e.idx, e.ci, e.op, e.co, e.bv, e.cb);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed cases first, then randomized instruction stream
    initial begin
        ctl.mem_ready = 1'b0;
        ctl.alu_eq    = 1'b0;
        ctl.alu_lt    = 1'b0;
        ctl.alu_ltu   = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        sb_q.push_back(wo(wi(rec(ST_FETCH, 16'h0, 1'b0), 5'd0), 4'd0));

        run_inst(32'h00500093, 0, 0, 0, 1'b0, 1'b0, 1'b0); // ADDI x1,x0,5
        run_inst(32'h00500013, 2, 0, 0, 1'b0, 1'b0, 1'b0); // ADDI x0 with fetch waits
        run_inst(32'h00209463, 0, 0, 0, 1'b0, 1'b0, 1'b0); // BNE taken
        run_inst(32'h00209463, 0, 0, 0, 1'b1, 1'b0, 1'b0); // BNE not taken
        run_inst(32'h0000A103, 0, 3, 0, 1'b0, 1'b0, 1'b0); // LW, 3 wait cycles
        run_inst(32'h402081B3, 0, 0, 0, 1'b0, 1'b0, 1'b0); // SUB
        run_inst(32'h4010D093, 0, 0, 0, 1'b0, 1'b0, 1'b0); // SRAI
        run_inst(32'h0010D093, 0, 0, 0, 1'b0, 1'b0, 1'b0); // SRLI
        run_inst(32'h0020A223, 1, 2, 0, 1'b0, 1'b0, 1'b0); // SW with waits
        run_inst(32'hABCDE3B7, 0, 0, 0, 1'b0, 1'b0, 1'b0); // LUI
        run_inst(32'h00001297, 0, 0, 0, 1'b0, 1'b0, 1'b0); // AUIPC x5,0x1
        run_inst(32'hFFFFFFFF, 0, 0, 0, 1'b0, 1'b0, 1'b0); // illegal -> halt -> reset
        run_inst(32'h0000A103, 0, 5, 5, 1'b0, 1'b0, 1'b0); // reset during load wait
        run_inst(32'h00500093, 0, 0, 0, 1'b0, 1'b0, 1'b0); // clean restart

        for (int n = 0; n < 80; n++) begin
            run_inst(rand_inst(), $urandom_range(2, 0), $urandom_range(3, 0),
                     (($urandom % 10) == 0) ? $urandom_range(6, 1) : 0, rb(), rb(), rb());
        end

        @(negedge clk); #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        if (n_bad != 0 || n_cmp == 0) begin
            $display("FAIL: %0d mismatches over %0d comparisons", n_bad, n_cmp);
        end else begin
            $display("PASS");
        end
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/control_seq.md
Name: control_seq

Overview:
- Parametrised multi-cycle control sequencer for the bus-based RISC-V datapath.
- Captures the instruction from the shared bus and decodes the opcode class and funct3 internally.
- Generates immediates and drives them onto the bus.
- Sequences the PC, register file, A/B latches, ALU and memory strobes.
- Adds over the previous sequencer:
  - memory wait-state handshake;
  - full funct3-driven branch conditions;
  - AUIPC;
  - funct3/funct7-derived ALU op;
  - sticky HALT on illegal instructions.

Parameters:
- XLEN, 32, datapath, bus and instruction-register width (≥32).
- REG_IDX_W, 5, register index width.
- ALU_OP_W, 4, ALU op width.
- MEM_WAIT_EN, 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- bus  inout  XLEN  shared data bus; driven with the immediate when imm_en=1, else 'z
- mem_ready  input  1  memory transfer complete this cycle
- alu_eq  input  1  A==B
- alu_lt  input  1  signed A<B
- alu_ltu  input  1  unsigned A<B
- reg_idx  output  REG_IDX_W  register file index
- pc_addr, pc_bus, pc_inc, pc_write  output  1 each  PC strobes
- mem_read, mem_write  output  1 each  memory strobes
- reg_en, reg_write  output  1 each  register file read enable / write
- a_bus, a_addr, a_write, b_bus, b_addr, b_write  output  1 each  operand latch strobes
- alu_bus, alu_addr  output  1 each  ALU result to bus / address
- alu_op  output  ALU_OP_W  ALU operation
- halted  output  1  sticky; an illegal instruction was seen
- state_o  output  4  current state, for debug

Behaviour:

Reset and timing:
- On reset (asynchronous): state=FETCH, inst=0, halted=0, every strobe 0, reg_idx=0, alu_op=0, bus released.
- inst and state update on posedge clk.
- All strobe outputs are registered on negedge clk from the current state. Every strobe defaults to 0 each negedge, so strobes are single-state pulses.

Decode:
- Opcode class = inst[6:2].
- Immediates:
  - I = sext(inst[31:20])
  - S = sext({inst[31:25], inst[11:7]})
  - B = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - U = {inst[31:12], 12'b0}
- All immediates are sign-extended to XLEN.

States:
- FETCH:
  - pc_addr=1, mem_read=1, inst_write=1.
  - Stays in FETCH while mem_ready=0; inst is captured on the posedge with mem_ready=1.
  - Then goes to REGA.
- REGA:
  - Illegal class or illegal branch funct3 (010/011) → HALT.
  - Otherwise reg_idx=rs1, reg_en=1, a_write=1; pc_inc=1 unless class is BRANCH (11000) or AUIPC (00101).
  - Then REGB.
- REGB:
  - OP_IMM (00100), LOAD and STORE put the immediate on the bus (imm_en=1, b_write=1): I-imm for OP_IMM and LOAD, S-imm for STORE.
  - For STORE the rs2 store data is then read in EXEC1.
  - Otherwise reg_idx=rs2, reg_en=1, b_write=1.
  - Then EXEC.
- EXEC, per class:
  - LOAD: alu_op=ADD(0), alu_addr=1, mem_read=1, reg_idx=rd, reg_write=1. Holds while mem_ready=0, with reg_write asserted only in the mem_ready cycle. → FETCH.
  - STORE: alu_op=ADD, alu_addr=1, then → EXEC1.
  - EXEC1 (STORE only): alu_addr=1, reg_idx=rs2, reg_en=1, mem_write=1. Holds until mem_ready. → FETCH.
  - OP: alu_op={inst[30], funct3}.
  - OP_IMM: alu_op={inst[30]&(funct3==101), funct3}.
  - OP and OP_IMM both assert alu_bus=1, reg_idx=rd, reg_write=1. → FETCH.
  - LUI: imm_en (U-imm), reg_idx=rd, reg_write=1. → FETCH.
  - BRANCH: taken = funct3 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
    - Taken → PCA.
    - Not taken → pc_inc=1, → FETCH.
  - AUIPC: → PCA.
- PCA: pc_bus=1, a_write=1 → PCB.
- PCB: imm_en=1 (B-imm for BRANCH, U-imm for AUIPC), b_write=1, alu_op=ADD → PCW.
- PCW: alu_op=ADD, alu_bus=1, then:
  - BRANCH: pc_write=1.
  - AUIPC: reg_idx=rd, reg_write=1, pc_inc=1.
  - → FETCH.
- HALT:
  - halted=1, all strobes 0.
  - Left only by reset.

Boundary conditions:
- rd=0 still pulses reg_write; the register file discards the write.
- Reset asserted mid-instruction (including during a mem wait) returns to FETCH immediately with strobes cleared.
- With MEM_WAIT_EN=0, every memory state lasts exactly one cycle.

Latency (mem_ready=1):
- ALU/LUI: 4 cycles.
- LOAD: 4 cycles.
- STORE: 5 cycles.
- Branch not taken: 4 cycles.
- Branch taken: 7 cycles.
- AUIPC: 7 cycles.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready=1:
  - FETCH→REGA→REGB→EXEC→FETCH in 4 cycles.
  - bus=0x5 during REGB; reg_idx=1 with reg_write in EXEC; alu_op=0.
- BNE with alu_eq=0, imm=+8 (0x00209463):
  - PCA/PCB/PCW visited.
  - bus=0x8 in PCB; pc_write=1 in PCW; pc_inc never asserted.
  - Same instruction with alu_eq=1: pc_inc in EXEC, 4 cycles total.
- LW with mem_ready low for 3 cycles in EXEC:
  - state_o holds EXEC for 3 cycles.
  - reg_write pulses only in the mem_ready cycle; alu_addr stays high throughout.
- SUB x3,x1,x2 (0x402081b3): alu_op=4'b1000. SRAI (0x4010d093): alu_op=4'b1101. SRLI: alu_op=4'b0101.
- Illegal opcode 0xFFFFFFFF:
  - halted=1 after REGA and stays 1 for 20 cycles with no strobes.
  - Asynchronous reset pulse clears halted and returns to FETCH.
- AUIPC x5,0x1 (0x00001297):
  - bus=0x1000 in PCB; reg_idx=5 with reg_write and pc_inc in PCW; 7 cycles.
